// File: rtl/i2c_seq_ctrl_pkg.sv
// Shared types and constants for the I2C transaction sequencer.
package i2c_seq_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 4;
  localparam int CMD_W  = 3;

  // Bit-engine command encodings; 0 is the idle/reset value of eng_cmd.
  typedef enum logic [CMD_W-1:0] {
    CMD_NONE      = 3'd0,
    CMD_START     = 3'd1,
    CMD_WRITE     = 3'd2,
    CMD_READ_ACK  = 3'd3,
    CMD_READ_NACK = 3'd4,
    CMD_STOP      = 3'd5
  } eng_cmd_e;

  // Sequencer states; each non-IDLE state owns exactly one engine command.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

  // First byte on the wire after START: 7-bit address then R/W bit.
  function automatic logic [BYTE_W-1:0] addr_byte(input logic [ADDR_W-1:0] addr,
                                                  input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_seq_ctrl_if.sv
// Command/response bus between the sequencer (master) and the I2C bit engine (slave).
//
// Handshake: the master raises eng_cmd_valid for one cycle only while eng_ready
// is high and then holds eng_cmd/eng_wdata stable; the engine answers with a
// one-cycle eng_done, and eng_nack/eng_rdata are meaningful only in that cycle.
interface i2c_seq_ctrl_if;
  import i2c_seq_ctrl_pkg::*;

  logic [CMD_W-1:0]  eng_cmd;
  logic              eng_cmd_valid;
  logic [BYTE_W-1:0] eng_wdata;
  logic              eng_ready;
  logic              eng_done;
  logic              eng_nack;
  logic [BYTE_W-1:0] eng_rdata;

  modport master (
    output eng_cmd, eng_cmd_valid, eng_wdata,
    input  eng_ready, eng_done, eng_nack, eng_rdata
  );

  modport slave (
    input  eng_cmd, eng_cmd_valid, eng_wdata,
    output eng_ready, eng_done, eng_nack, eng_rdata
  );

endinterface

// File: rtl/i2c_seq_ctrl_wdog.sv
// Per-command timeout counter: cleared when a command is issued, counts while
// the sequencer waits for eng_done, and saturates at TIMEOUT_CYC.
module i2c_seq_wdog #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYC));

  // Count wait cycles; holding at the limit keeps expired stable until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_seq_ctrl.sv
// I2C transaction sequencer: turns one request (rw, addr, len) into the
// START / address / data / STOP command sequence for a bit-level engine.
//
// Handshakes: req is accepted on req_valid && req_ready; a write byte is
// consumed on wr_valid && wr_ready; rd_valid/done/nack_err/tmo_err are
// one-cycle pulses with no back-pressure.
module i2c_seq_ctrl
  import i2c_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              nack_err,
  output logic              tmo_err,
  output state_e            state_dbg,
  i2c_seq_ctrl_if.master    eng
);

  state_e            state;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt;
  logic              outstanding;  // command issued, eng_done not yet seen
  logic              nack_pend;    // NACK seen; reported with done after STOP
  logic              wait_done;
  logic              can_issue;
  logic              expired;

  // The issue cycle itself is excluded so a done can only answer a visible command.
  assign wait_done = outstanding && !eng.eng_cmd_valid;
  assign can_issue = !outstanding && eng.eng_ready;
  assign req_ready = !rst && (state == ST_IDLE) && !done && !nack_err && !tmo_err;
  assign wr_ready  = !rst && (state == ST_WDATA) && can_issue;
  assign state_dbg = state;

  i2c_seq_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (eng.eng_cmd_valid),
    .en      (wait_done),
    .expired (expired)
  );

  // Sequencer FSM: issue one command per state, then wait for its completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      rw_q              <= 1'b0;
      addr_q            <= '0;
      cnt               <= '0;
      outstanding       <= 1'b0;
      nack_pend         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      nack_err          <= 1'b0;
      tmo_err           <= 1'b0;
      rd_valid          <= 1'b0;
      rd_data           <= '0;
      eng.eng_cmd       <= CMD_NONE;
      eng.eng_cmd_valid <= 1'b0;
      eng.eng_wdata     <= '0;
    end else begin
      done              <= 1'b0;
      nack_err          <= 1'b0;
      tmo_err           <= 1'b0;
      rd_valid          <= 1'b0;
      eng.eng_cmd_valid <= 1'b0;

      if (wait_done && eng.eng_done) begin
        outstanding <= 1'b0;
        case (state)
          ST_START: state <= ST_ADDR;
          ST_ADDR: begin
            if (eng.eng_nack) begin
              nack_pend <= 1'b1;
              state     <= ST_STOP;
            end else if (cnt == '0) begin
              state <= ST_STOP;
            end else begin
              state <= rw_q ? ST_RDATA : ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (cnt != '0) cnt <= cnt - 4'd1;
            if (eng.eng_nack) begin
              nack_pend <= 1'b1;
              state     <= ST_STOP;
            end else if (cnt == 4'd1) begin
              state <= ST_STOP;
            end
          end
          ST_RDATA: begin
            rd_data  <= eng.eng_rdata;
            rd_valid <= 1'b1;
            if (cnt != '0) cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ST_STOP;
          end
          ST_STOP: begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            nack_err  <= nack_pend;
            nack_pend <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (wait_done && expired) begin
        // Engine is stuck: abandon the transfer without trying to send STOP.
        state       <= ST_IDLE;
        outstanding <= 1'b0;
        nack_pend   <= 1'b0;
        busy        <= 1'b0;
        tmo_err     <= 1'b1;
      end else if (!outstanding) begin
        case (state)
          ST_IDLE: begin
            if (req_valid && req_ready) begin
              rw_q      <= req_rw;
              addr_q    <= req_addr;
              cnt       <= req_len;
              nack_pend <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_START;
            end
          end
          ST_START: begin
            if (can_issue) begin
              eng.eng_cmd       <= CMD_START;
              eng.eng_cmd_valid <= 1'b1;
              outstanding       <= 1'b1;
            end
          end
          ST_ADDR: begin
            if (can_issue) begin
              eng.eng_cmd       <= CMD_WRITE;
              eng.eng_wdata     <= addr_byte(addr_q, rw_q);
              eng.eng_cmd_valid <= 1'b1;
              outstanding       <= 1'b1;
            end
          end
          ST_WDATA: begin
            if (wr_valid && wr_ready) begin
              eng.eng_cmd       <= CMD_WRITE;
              eng.eng_wdata     <= wr_data;
              eng.eng_cmd_valid <= 1'b1;
              outstanding       <= 1'b1;
            end
          end
          ST_RDATA: begin
            if (can_issue) begin
              eng.eng_cmd       <= (cnt == 4'd1) ? CMD_READ_NACK : CMD_READ_ACK;
              eng.eng_cmd_valid <= 1'b1;
              outstanding       <= 1'b1;
            end
          end
          ST_STOP: begin
            if (can_issue) begin
              eng.eng_cmd       <= CMD_STOP;
              eng.eng_cmd_valid <= 1'b1;
              outstanding       <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Self-checking bench for i2c_seq_ctrl: directed and random transactions
// against a behavioural engine model and a transaction-level reference.
module tb_i2c_seq_ctrl;
  import i2c_seq_ctrl_pkg::*;

  localparam int TMO = 1023;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rw;
  logic [6:0]  req_addr;
  logic [3:0]  req_len;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, done, nack_err, tmo_err;
  state_e      state_dbg;
  int          cyc = 0;

  i2c_seq_ctrl_if eng_if ();

  i2c_seq_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .nack_err(nack_err), .tmo_err(tmo_err),
    .state_dbg(state_dbg),
    .eng(eng_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL global_time_limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int tests_run = 0, tests_failed = 0;

  logic [10:0] exp_q[$];      // expected {cmd, wdata} per engine command
  logic [7:0]  exp_rd_q[$];
  logic        exp_done, exp_nack, exp_tmo;
  int          exp_consumed;

  logic [10:0] obs_q[$];      // commands the engine model saw
  int          obs_cyc_q[$];

  logic [7:0]  tb_wb[$];      // write bytes offered by the producer
  logic [7:0]  tb_rsrc[$];    // read bytes the engine will return
  logic [7:0]  rd_src_q[$];

  int   nack_idx = -1;        // WRITE index (0 = address) the engine NACKs
  int   wh_idx   = -1;        // command index whose eng_done is withheld
  logic eng_abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural I2C bit engine ----------------
  initial begin : engine
    logic       active, hold, pnack;
    logic [7:0] prdata;
    int         lat, wr_idx;
    active = 0; hold = 0; pnack = 0; prdata = 0; lat = 0; wr_idx = 0;
    eng_if.eng_ready = 1'b1;
    eng_if.eng_done  = 1'b0;
    eng_if.eng_nack  = 1'b0;
    eng_if.eng_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      eng_if.eng_done = 1'b0;
      eng_if.eng_nack = 1'b0;
      if (rst || eng_abort) begin
        active = 0;
        eng_if.eng_ready = 1'b1;
      end else if (active) begin
        if (lat > 0) lat--;
        else if (!hold) begin
          eng_if.eng_done  = 1'b1;
          eng_if.eng_nack  = pnack;
          eng_if.eng_rdata = prdata;
          eng_if.eng_ready = 1'b1;
          active = 0;
        end
      end else if (eng_if.eng_cmd_valid) begin
        obs_q.push_back({eng_if.eng_cmd, eng_if.eng_wdata});
        obs_cyc_q.push_back(cyc);
        hold  = ((obs_q.size() - 1) == wh_idx);
        pnack = 1'b0;
        case (eng_if.eng_cmd)
          CMD_START: wr_idx = 0;
          CMD_WRITE: begin
            pnack = (wr_idx == nack_idx);
            wr_idx++;
          end
          CMD_READ_ACK, CMD_READ_NACK: begin
            if (rd_src_q.size() > 0) prdata = rd_src_q.pop_front();
            else prdata = 8'h00;
          end
          default: ;
        endcase
        active = 1;
        eng_if.eng_ready = 1'b0;
        lat = $urandom_range(0, 3);
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  task automatic build_exp(input logic rw, input logic [6:0] addr, input int len,
                           input int nidx, input int widx);
    logic        nacked;
    eng_cmd_e    c;
    logic [10:0] e;
    int          ri;
    exp_q.delete();
    exp_rd_q.delete();
    exp_q.push_back({CMD_START, 8'h00});
    exp_q.push_back({CMD_WRITE, addr, rw});
    nacked = (nidx == 0);
    if (!nacked) begin
      for (int i = 1; i <= len; i++) begin
        if (rw) begin
          c = (i == len) ? CMD_READ_NACK : CMD_READ_ACK;
          exp_q.push_back({c, 8'h00});
        end else begin
          exp_q.push_back({CMD_WRITE, tb_wb[i-1]});
          if (nidx == i) begin
            nacked = 1'b1;
            break;
          end
        end
      end
    end
    exp_q.push_back({CMD_STOP, 8'h00});
    if (widx >= 0 && widx < exp_q.size()) begin
      while (exp_q.size() > widx + 1) void'(exp_q.pop_back());
      exp_tmo = 1'b1; exp_done = 1'b0; exp_nack = 1'b0;
    end else begin
      exp_tmo = 1'b0; exp_done = 1'b1; exp_nack = nacked;
    end
    ri = 0;
    exp_consumed = 0;
    for (int i = 2; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (e[10:8] == CMD_READ_ACK || e[10:8] == CMD_READ_NACK) begin
        if (!(exp_tmo && i == exp_q.size() - 1)) exp_rd_q.push_back(tb_rsrc[ri]);
        ri++;
      end
      if (e[10:8] == CMD_WRITE) exp_consumed++;
    end
  endtask

  // ---------------- driver + checker for one transaction ----------------
  task automatic run_txn(input string name, input logic rw, input logic [6:0] addr,
                         input int len, input int nidx, input int widx,
                         input int stall, input int rst_at);
    logic [7:0]  wq[$];
    logic [7:0]  got_rd[$];
    logic [10:0] e, o;
    int   k, done_cnt, nack_cnt, tmo_cnt, consumed, ready_seen, tmo_cyc;
    logic fin, pend, aborted, saw_stop;
    build_exp(rw, addr, len, nidx, widx);
    wq = tb_wb;
    rd_src_q = tb_rsrc;
    nack_idx = nidx;
    wh_idx = widx;
    obs_q.delete();
    obs_cyc_q.delete();
    done_cnt = 0; nack_cnt = 0; tmo_cnt = 0; consumed = 0; ready_seen = 0; tmo_cyc = 0;
    fin = 0; pend = 0; aborted = 0;

    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_len = len[3:0];
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    check({name, ":accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, ":busy_after_accept"}, 32'(busy), 32'd1);

    for (int cy = 0; cy < 4000 + stall && !fin; cy++) begin
      if (pend) begin
        void'(wq.pop_front());
        consumed++;
        wr_valid = 1'b0;
      end
      if (rd_valid) got_rd.push_back(rd_data);
      if (nack_err) nack_cnt++;
      if (done) begin
        done_cnt++;
        check({name, ":req_ready_at_done"}, 32'(req_ready), 32'd0);
        fin = 1;
      end
      if (tmo_err) begin
        tmo_cnt++;
        tmo_cyc = cyc;
        fin = 1;
      end
      if (wr_ready) ready_seen++;
      if (fin) wr_valid = 1'b0;
      else if (!wr_valid && wq.size() > 0 && ready_seen > stall && $urandom_range(0, 3) != 0) begin
        wr_valid = 1'b1;
        wr_data  = wq[0];
      end
      pend = wr_valid && wr_ready;
      if (rst_at > 0 && got_rd.size() >= rst_at) begin
        rst = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk);
        check({name, ":rst_busy"},      32'(busy),              32'd0);
        check({name, ":rst_done"},      32'(done),              32'd0);
        check({name, ":rst_nack"},      32'(nack_err),          32'd0);
        check({name, ":rst_tmo"},       32'(tmo_err),           32'd0);
        check({name, ":rst_rd_valid"},  32'(rd_valid),          32'd0);
        check({name, ":rst_rd_data"},   32'(rd_data),           32'd0);
        check({name, ":rst_cmd_valid"}, 32'(eng_if.eng_cmd_valid), 32'd0);
        check({name, ":rst_cmd"},       32'(eng_if.eng_cmd),    32'd0);
        check({name, ":rst_wdata"},     32'(eng_if.eng_wdata),  32'd0);
        check({name, ":rst_req_ready"}, 32'(req_ready),         32'd0);
        check({name, ":rst_wr_ready"},  32'(wr_ready),          32'd0);
        rst = 1'b0;
        @(negedge clk);
        check({name, ":post_rst_req_ready"}, 32'(req_ready), 32'd1);
        check({name, ":post_rst_done"},      32'(done | nack_err | tmo_err), 32'd0);
        saw_stop = 0;
        foreach (obs_q[i]) begin
          o = obs_q[i];
          if (o[10:8] == CMD_STOP) saw_stop = 1;
        end
        check({name, ":no_stop_on_rst"}, 32'(saw_stop), 32'd0);
        aborted = 1;
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    check({name, ":finished_in_budget"}, 32'(fin), 32'd1);

    if (!aborted) begin
      check({name, ":cmd_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        e = exp_q[i];
        o = obs_q[i];
        check($sformatf("%s:cmd%0d", name, i), 32'(o[10:8]), 32'(e[10:8]));
        if (e[10:8] == CMD_WRITE)
          check($sformatf("%s:wdata%0d", name, i), 32'(o[7:0]), 32'(e[7:0]));
      end
      check({name, ":rd_count"}, 32'(got_rd.size()), 32'(exp_rd_q.size()));
      for (int i = 0; i < exp_rd_q.size() && i < got_rd.size(); i++)
        check($sformatf("%s:rd%0d", name, i), 32'(got_rd[i]), 32'(exp_rd_q[i]));
      check({name, ":done"},     32'(done_cnt), 32'(exp_done));
      check({name, ":nack_err"}, 32'(nack_cnt), 32'(exp_nack));
      check({name, ":tmo_err"},  32'(tmo_cnt),  32'(exp_tmo));
      if (!rw) check({name, ":bytes_consumed"}, 32'(consumed), 32'(exp_consumed));
      if (exp_tmo && obs_cyc_q.size() > 0) begin
        k = tmo_cyc - obs_cyc_q[obs_cyc_q.size() - 1];
        check({name, ":tmo_latency_ok"}, 32'(k >= TMO && k <= TMO + 4), 32'd1);
      end
      @(negedge clk);
      check({name, ":busy_after_end"},      32'(busy),      32'd0);
      check({name, ":req_ready_after_end"}, 32'(req_ready), 32'd1);
    end

    if (exp_tmo) begin
      eng_abort = 1'b1;
      @(negedge clk);
      eng_abort = 1'b0;
    end
    nack_idx = -1;
    wh_idx   = -1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stimulus
    logic       rw;
    int         len, nidx;
    logic [6:0] addr;
    rst = 1'b1; req_valid = 0; req_rw = 0; req_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    check("reset:req_ready", 32'(req_ready), 32'd0);
    check("reset:busy",      32'(busy),      32'd0);
    check("reset:cmd_valid", 32'(eng_if.eng_cmd_valid), 32'd0);
    check("reset:cmd",       32'(eng_if.eng_cmd),   32'd0);
    check("reset:wdata",     32'(eng_if.eng_wdata), 32'd0);
    check("reset:rd_data",   32'(rd_data),   32'd0);
    check("reset:wr_ready",  32'(wr_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset:req_ready_after", 32'(req_ready), 32'd1);

    tb_wb = '{8'hA5, 8'h3C}; tb_rsrc.delete();
    run_txn("wr2", 1'b0, 7'h50, 2, -1, -1, 0, 0);

    tb_wb.delete(); tb_rsrc = '{8'h11, 8'h22, 8'h33};
    run_txn("rd3", 1'b1, 7'h21, 3, -1, -1, 0, 0);

    tb_wb.delete(); tb_rsrc.delete();
    run_txn("probe_nack", 1'b0, 7'h21, 0, 0, -1, 0, 0);

    tb_wb = '{8'h01, 8'h02, 8'h03}; tb_rsrc.delete();
    run_txn("wr_nack_b2", 1'b0, 7'h3A, 3, 2, -1, 0, 0);

    tb_wb = '{8'hDE, 8'hAD}; tb_rsrc.delete();
    run_txn("tmo", 1'b0, 7'h12, 2, -1, 2, 0, 0);

    tb_wb = '{8'h5A}; tb_rsrc.delete();
    run_txn("wr_stall", 1'b0, 7'h33, 1, -1, -1, 2000, 0);

    tb_wb.delete(); tb_rsrc.delete();
    run_txn("probe_ack", 1'b1, 7'h7F, 0, -1, -1, 0, 0);

    for (int t = 0; t < 10; t++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 127));
      len  = $urandom_range(0, 15);
      tb_wb.delete(); tb_rsrc.delete();
      for (int i = 0; i < len; i++) begin
        tb_wb.push_back(8'($urandom_range(0, 255)));
        tb_rsrc.push_back(8'($urandom_range(0, 255)));
      end
      if (rw) nidx = ($urandom_range(0, 4) == 0) ? 0 : -1;
      else    nidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
      run_txn($sformatf("rand%0d", t), rw, addr, len, nidx, -1, 0, 0);
    end

    tb_wb.delete(); tb_rsrc = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
    run_txn("rd_rst", 1'b1, 7'h44, 5, -1, -1, 0, 2);

    tb_wb.delete(); tb_rsrc = '{8'hC3, 8'h3C};
    run_txn("rd_after_rst", 1'b1, 7'h45, 2, -1, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
